mesh_term_fifo_bank: RTL

Parametrised bank of per-terminal FIFOs at the mesh boundary; one independent channel per terminal, NUM_CH channels (16 for the current 4x4 mesh).
Each channel buffers pckg_sz-bit packets and presents them first-word-fall-through with a pending flag.

---
 rtl/mesh_fifo_pkg.sv | 24 ++
 rtl/mesh_fifo_ch.sv | 88 ++++++++
 rtl/mesh_term_fifo_bank.sv | 49 ++++
 3 files changed

// File: rtl/mesh_fifo_pkg.sv
// Shared types and helpers for the mesh terminal FIFO bank: overflow mode,
// occupancy/pointer width helpers and channel slice offsets.
package mesh_fifo_pkg;

  typedef enum logic {
    OVF_DROP      = 1'b0,
    OVF_OVERWRITE = 1'b1
  } ovf_mode_e;

  // Occupancy must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // Low bit of channel ch in a flat vector of w-bit slices.
  function automatic int slice_lo(input int ch, input int w);
    return ch * w;
  endfunction

endpackage

// File: rtl/mesh_fifo_ch.sv
// Single first-word-fall-through terminal FIFO channel with registered status
// flags, selectable overflow handling and a sticky overflow indicator.
module mesh_fifo_ch
  import mesh_fifo_pkg::*;
#(
  parameter int PW       = 40,
  parameter int DEPTH    = 4,
  parameter int OVF_MODE = 0,
  parameter int AF_LEVEL = DEPTH - 1,
  localparam int CW      = cnt_w(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_push,
  input  logic [PW-1:0] i_data,
  input  logic          i_pop,
  input  logic          i_ovf_clr,
  output logic [PW-1:0] o_data,
  output logic          o_pndng,
  output logic          o_full,
  output logic          o_almost_full,
  output logic [CW-1:0] o_count,
  output logic          o_ovf_sticky
);

  localparam int              PTRW     = ptr_w(DEPTH);
  localparam logic [PTRW-1:0] PTR_LAST = PTRW'(DEPTH - 1);
  localparam logic [CW-1:0]   CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0]   CNT_AF   = CW'(AF_LEVEL);
  localparam ovf_mode_e       MODE     = (OVF_MODE != 0) ? OVF_OVERWRITE : OVF_DROP;

  // Strobe semantics: i_push/i_pop are single-cycle requests with no back-pressure;
  // a pop is honoured only when o_pndng=1, a push on full follows MODE.
  logic [PW-1:0]   r_mem [DEPTH];
  logic [PTRW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_pndng, r_full, r_af, r_ovf;

  logic            w_do_pop, w_blocked, w_wr, w_rd_adv;
  logic [CW-1:0]   w_count_nxt;

  function automatic logic [PTRW-1:0] next_ptr(input logic [PTRW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    w_do_pop    = i_pop && r_pndng;
    // Full with no simultaneous read frees no slot: this is an overflow event.
    w_blocked   = i_push && r_full && !w_do_pop;
    w_wr        = i_push && (!w_blocked || (MODE == OVF_OVERWRITE));
    w_rd_adv    = w_do_pop || (w_blocked && (MODE == OVF_OVERWRITE));
    w_count_nxt = r_count + CW'(w_wr) - CW'(w_rd_adv);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_pndng  <= 1'b0;
      r_full   <= 1'b0;
      r_af     <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr)     r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_rd_adv) r_rd_ptr <= next_ptr(r_rd_ptr);
      r_count <= w_count_nxt;
      r_pndng <= (w_count_nxt != '0);
      r_full  <= (w_count_nxt == CNT_FULL);
      r_af    <= (w_count_nxt >= CNT_AF);
      // Set has priority over clear.
      if (w_blocked)      r_ovf <= 1'b1;
      else if (i_ovf_clr) r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset && w_wr) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data        = r_pndng ? r_mem[r_rd_ptr] : '0;
  assign o_pndng       = r_pndng;
  assign o_full        = r_full;
  assign o_almost_full = r_af;
  assign o_count       = r_count;
  assign o_ovf_sticky  = r_ovf;

endmodule

// File: rtl/mesh_term_fifo_bank.sv
// Bank of independent per-terminal FIFO channels at the mesh boundary; this
// level only unpacks/packs the flat per-channel buses.
module mesh_term_fifo_bank
  import mesh_fifo_pkg::*;
#(
  parameter int pckg_sz    = 40,
  parameter int fifo_depth = 4,
  parameter int NUM_CH     = 16,
  parameter int OVF_MODE   = 0,
  parameter int AF_LEVEL   = fifo_depth - 1,
  localparam int CW        = cnt_w(fifo_depth)
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [NUM_CH-1:0]         i_push,
  input  logic [NUM_CH*pckg_sz-1:0] i_data_in,
  input  logic [NUM_CH-1:0]         i_pop,
  input  logic [NUM_CH-1:0]         i_ovf_clr,
  output logic [NUM_CH*pckg_sz-1:0] o_data_out,
  output logic [NUM_CH-1:0]         o_pndng,
  output logic [NUM_CH-1:0]         o_full,
  output logic [NUM_CH-1:0]         o_almost_full,
  output logic [NUM_CH*CW-1:0]      o_count,
  output logic [NUM_CH-1:0]         o_ovf_sticky
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    mesh_fifo_ch #(
      .PW       (pckg_sz),
      .DEPTH    (fifo_depth),
      .OVF_MODE (OVF_MODE),
      .AF_LEVEL (AF_LEVEL)
    ) u_ch (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .i_push        (i_push[g]),
      .i_data        (i_data_in[slice_lo(g, pckg_sz) +: pckg_sz]),
      .i_pop         (i_pop[g]),
      .i_ovf_clr     (i_ovf_clr[g]),
      .o_data        (o_data_out[slice_lo(g, pckg_sz) +: pckg_sz]),
      .o_pndng       (o_pndng[g]),
      .o_full        (o_full[g]),
      .o_almost_full (o_almost_full[g]),
      .o_count       (o_count[slice_lo(g, CW) +: CW]),
      .o_ovf_sticky  (o_ovf_sticky[g])
    );
  end

endmodule
